uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit serializer (TxData to PC) between NUM_REQ on-chip requesters.
- Arbitration is round-robin and frame-locked: a granted requester keeps the serializer until it sends the byte marked last, or until it stalls past a timeout.
- Sits between the requester logic and the UART TX bit engine, in the 100 MHz domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width.
- TIMEOUT_CYC, 1000, idle cycles allowed mid-frame before the grant is revoked (counter is 16 bits).

Ports:
- CpSl_Clk_i  in  1  system clock, 100 MHz.
- CpSl_Rst_iN  in  1  asynchronous reset, active low.
- CpSv_ReqVld_i  in  NUM_REQ  per-requester byte valid.
- CpSv_ReqData_i  in  NUM_REQ*DATA_W  packed bytes; requester i occupies [i*DATA_W +: DATA_W].
- CpSv_ReqLast_i  in  NUM_REQ  byte is the last of its frame.
- CpSv_ReqRdy_o  out  NUM_REQ  one-cycle byte-accepted pulse.
- CpSv_Grant_o  out  NUM_REQ  one-hot current owner; all-zero when idle.
- CpSl_TxStart_o  out  1  one-cycle start pulse to the serializer.
- CpSv_TxData_o  out  DATA_W  byte to the serializer, valid with TxStart.
- CpSl_TxBusy_i  in  1  serializer busy.
- CpSl_Timeout_o  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset: one clock, async active-low reset. All outputs are registered and reset to 0. State resets to IDLE. The round-robin pointer (last-granted index) resets to NUM_REQ-1, so requester 0 has first priority.
- IDLE:
  - If any ReqVld is high, pick the first set bit searching from pointer+1 with wrap-around.
  - Grant_o becomes one-hot on the next edge; go to SEND.
  - Otherwise stay in IDLE.
- SEND, owner g:
  - If ReqVld[g]=1 and TxBusy=0: on the next edge register TxStart_o=1, TxData_o=ReqData[g], ReqRdy_o[g]=1, latch last_flag=ReqLast[g], clear the timeout counter, go to WAIT_BUSY.
  - If ReqVld[g]=0: increment the timeout counter. When it reaches TIMEOUT_CYC-1: Timeout_o=1 for one cycle, Grant_o=0, pointer=g, go to IDLE.
  - TxBusy=1 while ReqVld[g]=1 only holds; it does not advance the timeout counter.
- WAIT_BUSY: wait for TxBusy=1. If TxBusy has not risen 2 cycles after TxStart, proceed anyway (fast serializer). Go to WAIT_DONE.
- WAIT_DONE: wait for TxBusy=0.
  - last_flag=1: Grant_o=0, pointer=g, go to IDLE.
  - last_flag=0: return to SEND.
- Handshake: the requester holds Vld, Data and Last stable until it sees its Rdy pulse. Data is sampled in the SEND cycle before the Rdy pulse. Rdy, TxStart and Data are coincident.
- Latency: ReqVld high at cycle N in IDLE -> Grant at N+1 -> TxStart/Rdy at N+2.
- Maximum rate: one byte per serializer period + 2 cycles.
- Grant persistence: dropping ReqVld mid-frame never releases the grant; only Last or timeout does.
- Non-owners: requests from non-owners are ignored (Rdy=0) until release. The arbiter never starves a requester: the worst-case wait is NUM_REQ-1 frames.
- Release timing: a freed grant is re-arbitrated in the IDLE cycle after release. At least one IDLE cycle always separates frames.
- Single requester: the same requester may win again if it is the only one requesting.
- Reset mid-operation: asserting reset at any point clears Grant, TxStart and Rdy immediately. The serializer's in-flight byte is not this block's concern.

Test Plan:
- Single frame: ReqVld[1]=1 with bytes 0x41,0x42 (Last on 0x42); serializer busy for 10 cycles per byte -> Grant=4'b0010 at N+1, TxStart with 0x41 at N+2, 0x42 after busy falls, Grant=0 after second busy falls.
- Round-robin: all four requesters hold 1-byte frames continuously from reset -> grant order 0,1,2,3,0; each Rdy pulses exactly once per frame.
- Frame lock: requester 0 sends a 3-byte frame while requester 2 requests throughout -> Grant stays 4'b0001 for all 3 bytes; requester 2 is granted next.
- Timeout: TIMEOUT_CYC=16; requester 3 sends 1 non-last byte, then drops Vld -> Timeout_o pulses 16 cycles after entering SEND, Grant=0, next winner is requester 0.
- Busy hold: TxBusy forced high while ReqVld[0]=1 in SEND for 50 cycles with TIMEOUT_CYC=16 -> no TxStart and no Timeout; TxStart occurs 1 cycle after TxBusy falls.
- Async reset mid-frame: CpSl_Rst_iN pulsed low during WAIT_DONE -> all outputs 0 without a clock edge; the next request from requester 0 is granted first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// Round-robin, frame-locked arbiter sharing one UART TX serializer among NUM_REQ requesters.
// A grant is held until the owner's Last byte completes or the owner stalls past TIMEOUT_CYC.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                      CpSl_Clk_i,
    input  logic                      CpSl_Rst_iN,
    input  logic [NUM_REQ-1:0]        CpSv_ReqVld_i,
    input  logic [NUM_REQ*DATA_W-1:0] CpSv_ReqData_i,
    input  logic [NUM_REQ-1:0]        CpSv_ReqLast_i,
    output logic [NUM_REQ-1:0]        CpSv_ReqRdy_o,
    output logic [NUM_REQ-1:0]        CpSv_Grant_o,
    output logic                      CpSl_TxStart_o,
    output logic [DATA_W-1:0]         CpSv_TxData_o,
    input  logic                      CpSl_TxBusy_i,
    output logic                      CpSl_Timeout_o
);
    localparam int          IDX_W    = $clog2(NUM_REQ);
    localparam int          CNT_W    = IDX_W + 1;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_owner;
    logic                r_last;
    logic [15:0]         r_tmo_cnt;
    logic                r_wb_cnt;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  r_rdy;
    logic                r_tx_start;
    logic [DATA_W-1:0]   r_tx_data;
    logic                r_timeout;

    logic [2*NUM_REQ-1:0] w_vld_dbl;
    logic [NUM_REQ-1:0]   w_vld_rot;
    logic [CNT_W-1:0]     w_start;
    logic [CNT_W-1:0]     w_off;
    logic [CNT_W-1:0]     w_sum;
    logic [IDX_W-1:0]     w_pick;
    logic [NUM_REQ-1:0]   w_pick_oh;
    logic                 w_any;
    logic                 w_own_vld;
    logic                 w_own_last;
    logic [DATA_W-1:0]    w_own_data;

    // Rotate requests so bit 0 is the requester just after the last-granted one.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        w_vld_dbl = {CpSv_ReqVld_i, CpSv_ReqVld_i};
        w_start   = {1'b0, r_ptr} + CNT_W'(1);
        w_vld_rot = NUM_REQ'(w_vld_dbl >> w_start);
        w_any     = |w_vld_rot;
        w_off     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_vld_rot[k]) w_off = CNT_W'(k);
        end
        w_sum = w_start + w_off;
        if (w_sum >= CNT_W'(NUM_REQ)) w_sum = w_sum - CNT_W'(NUM_REQ);
        w_pick    = w_sum[IDX_W-1:0];
        w_pick_oh = NUM_REQ'(1) << w_pick;
    end

    always_comb begin
        w_own_vld  = |(CpSv_ReqVld_i & r_grant);
        w_own_last = |(CpSv_ReqLast_i & r_grant);
        w_own_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_grant[k]) w_own_data = w_own_data | CpSv_ReqData_i[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge CpSl_Clk_i or negedge CpSl_Rst_iN) begin
        if (!CpSl_Rst_iN) begin
            r_state    <= S_IDLE;
            r_ptr      <= IDX_W'(NUM_REQ - 1);
            r_owner    <= '0;
            r_last     <= 1'b0;
            r_tmo_cnt  <= '0;
            r_wb_cnt   <= 1'b0;
            r_grant    <= '0;
            r_rdy      <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_timeout  <= 1'b0;
        end else begin
            // NOTE: state uses nonblocking assignments; the pulse outputs default low and a branch raises them for one edge.
            r_tx_start <= 1'b0;
            r_rdy      <= '0;
            r_timeout  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant   <= w_pick_oh;
                        r_owner   <= w_pick;
                        r_tmo_cnt <= '0;
                        r_state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_own_vld) begin
                        if (!CpSl_TxBusy_i) begin
                            r_tx_start <= 1'b1;
                            r_tx_data  <= w_own_data;
                            r_rdy      <= r_grant;
                            r_last     <= w_own_last;
                            r_tmo_cnt  <= '0;
                            r_wb_cnt   <= 1'b0;
                            r_state    <= S_WAIT_BUSY;
                        end
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_timeout <= 1'b1;
                        r_grant   <= '0;
                        r_ptr     <= r_owner;
                        r_state   <= S_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
                end
                S_WAIT_BUSY: begin
                    // A serializer that never raises Busy is assumed done after two cycles.
                    if (CpSl_TxBusy_i || r_wb_cnt) r_state <= S_WAIT_DONE;
                    else                           r_wb_cnt <= 1'b1;
                end
                S_WAIT_DONE: begin
                    if (!CpSl_TxBusy_i) begin
                        if (r_last) begin
                            r_grant <= '0;
                            r_ptr   <= r_owner;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_SEND;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign CpSv_ReqRdy_o  = r_rdy;
    assign CpSv_Grant_o   = r_grant;
    assign CpSl_TxStart_o = r_tx_start;
    assign CpSv_TxData_o  = r_tx_data;
    assign CpSl_Timeout_o = r_timeout;

endmodule
